multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control sequencer for the MIPS-subset CPU. Each instruction is stepped through FETCH/DECODE/EXEC/MEM/WB states. A single instruction/data memory port is shared between fetch and load/store using a req/ready handshake. The block drives the per-cycle enables and mux selects of the shared datapath: PC, IR, register file, ALU and memory.

## Interface
- `CNT_W`, default 32: width of performance counters (used only with `MULTICYCLE_CTRL_PERF_EN`).

- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `instr_op_i` in 6: IR[31:26], valid from DECODE onward.
- `funct_i` in 6: IR[5:0].
- `branch_taken_i` in 1: datapath branch-condition result for the current `branch_type_o`.
- `mem_ready_i` in 1: memory completes the access this cycle.
- `mem_req_o` out 1: memory access request.
- `mem_we_o` out 1: write (sw).
- `mem_addr_sel_o` out 1: 0 = PC, 1 = ALU result.
- `ir_write_o` out 1: load IR from memory read data.
- `mdr_write_o` out 1: load MDR.
- `pc_write_o` out 1: PC update strobe.
- `pc_src_o` out 2: 00 = PC+4, 01 = branch target, 10 = rs (jr), 11 = jump target.
- `reg_write_o` out 1: register file write.
- `reg_dst_o` out 2: 00 = rt, 01 = rd, 10 = $31.
- `wb_src_o` out 2: 00 = ALU, 01 = MDR, 10 = imm<<16 (lui), 11 = PC+4 (jal).
- `alu_src_o` out 1: 0 = rt, 1 = immediate.
- `alu_op_o` out 3: 010 = R-type, 000 = add, 001 = branch compare, 011 = sltiu, 100 = ori, 101 = lui, 111 = don't care.
- `branch_type_o` out 2: 10 = beq, 11 = bne, 00 = ble, 01 = bltz.
- `cycle_cnt_o` out `CNT_W`: present only with the macro.
- `retire_cnt_o` out `CNT_W`: present only with the macro.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB. Reset enters IDLE; IDLE always goes to FETCH on the next edge.
- FETCH: `mem_req_o=1`, `mem_addr_sel_o=0`. In the handshake cycle (`mem_ready_i=1`), `ir_write_o=1`, `pc_write_o=1` and `pc_src_o=00`, then go to DECODE. Otherwise hold FETCH.
- DECODE:
  - j (0x02): `pc_write_o`, `pc_src_o=11`, then FETCH.
  - jr (op 0, funct 0x08): `pc_write_o`, `pc_src_o=10`, then FETCH.
  - jal (0x03): go to WB.
  - All other instructions go to EXEC.
- EXEC:
  - Branches are beq 0x04, bne 0x05, ble 0x06, bltz 0x01. Drive `alu_op_o=001` and `branch_type_o`; `pc_write_o=branch_taken_i` with `pc_src_o=01`; then FETCH.
  - lw 0x23 / sw 0x2B: `alu_op_o=000`, `alu_src_o=1`, then MEM.
  - R-type, addi 0x08, sltiu 0x0B, ori 0x0D, lui 0x0F: drive the matching `alu_op_o` / `alu_src_o`, then WB.
- MEM: `mem_req_o=1`, `mem_addr_sel_o=1`, `mem_we_o=(sw)`. Hold until `mem_ready_i`.
  - lw: `mdr_write_o=1` in the handshake cycle, then WB.
  - sw: FETCH.
- WB: `reg_write_o=1` for one cycle, with `reg_dst_o` / `wb_src_o` per instruction; then FETCH.
  - R-type nop (funct 0x00) suppresses `reg_write_o`.
- Unknown opcode executes as a nop: DECODE → EXEC → FETCH with no writes.
- Outputs are decoded from state plus `instr_op_i` / `funct_i`. Handshake strobes are combinationally gated by `mem_ready_i`.
- Every output not listed for a state is 0.

## Timing
- Zero-wait memory gives these instruction latencies: j/jr 2 cycles, branch 3, jal 3, R/I 4, sw 4, lw 5. Each cycle `mem_ready_i` is low in FETCH or MEM adds one cycle.
- `mem_req_o`, `mem_we_o` and `mem_addr_sel_o` stay stable while waiting. The request is never withdrawn before `mem_ready_i`.
- `mem_ready_i` outside FETCH/MEM is ignored.
- Asynchronous reset at any point forces IDLE immediately and drives all outputs to 0, including a pending `mem_req_o`. The interrupted instruction is abandoned.
- `pc_write_o` and `reg_write_o` are single-cycle pulses per instruction.

## Configuration
- `MULTICYCLE_CTRL_PERF_EN` defined: adds `cycle_cnt_o` and `retire_cnt_o`.
  - `cycle_cnt_o` increments every cycle out of reset.
  - `retire_cnt_o` increments on the final-state exit edge of each instruction: DECODE exit for j/jr, EXEC exit for branch/unknown, MEM exit for sw, WB exit otherwise.
  - Both counters reset to 0 and wrap modulo 2^`CNT_W`.
- Macro undefined: the counter ports and logic are absent.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum;
  - opcode and funct constants;
  - the `pc_src`, `wb_src`, `reg_dst`, `alu_op` and `branch_type` encodings.
- One sub-module, `mc_op_class`: combinational opcode/funct → instruction-class decode (rtype, jr, nop, j, jal, branch, load, store, imm_alu, lui, unknown). The FSM lives in `multicycle_ctrl`.

## Test plan
- Reset released, memory always ready, lw fetched:
  - IDLE, FETCH, DECODE, EXEC, MEM, WB, FETCH, i.e. 5 instruction cycles.
  - In WB: `reg_write_o=1`, `wb_src_o=01`, `reg_dst_o=00`.
- `mem_ready_i` low for 3 cycles during sw MEM:
  - `mem_req_o=1`, `mem_we_o=1` and `mem_addr_sel_o=1` are held for 4 cycles.
  - No `reg_write_o`; the instruction takes 7 cycles.
- beq with `branch_taken_i=1`, then again with 0: `pc_write_o` is 1 and then 0 in EXEC, with `pc_src_o=01` and `branch_type_o=10`.
- jal, then jr, then j:
  - jal: WB with `reg_dst_o=10` and `wb_src_o=11`.
  - jr: DECODE `pc_src_o=10`.
  - j: DECODE `pc_src_o=11`.
  - Latencies 3, 2 and 2 cycles.
- Reset asserted mid-MEM with `mem_req_o=1`: all outputs 0 immediately. After release, IDLE, then FETCH.
- With the macro defined, 10 R-type instructions at zero wait: `retire_cnt_o=10` and `cycle_cnt_o=41` (1 IDLE + 40).

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types for the multi-cycle control sequencer.
// Holds the FSM state enum, MIPS opcode/funct constants, the datapath
// select encodings (pc_src, wb_src, reg_dst, alu_op, branch_type) and the
// instruction-class record produced by mc_op_class.
package mc_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_BLTZ  = 6'h01;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_BLE   = 6'h06;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FN_NOP = 6'h00;
  localparam logic [FUNCT_W-1:0] FN_JR  = 6'h08;

  typedef enum logic [1:0] {
    PC_SRC_PC4    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_RS     = 2'b10,
    PC_SRC_JUMP   = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'b00,
    WB_SRC_MDR = 2'b01,
    WB_SRC_LUI = 2'b10,
    WB_SRC_PC4 = 2'b11
  } wb_src_e;

  typedef enum logic [1:0] {
    REG_DST_RT = 2'b00,
    REG_DST_RD = 2'b01,
    REG_DST_RA = 2'b10
  } reg_dst_e;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_BRCMP = 3'b001,
    ALU_RTYPE = 3'b010,
    ALU_SLTIU = 3'b011,
    ALU_ORI   = 3'b100,
    ALU_LUI   = 3'b101,
    ALU_DC    = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_BLE  = 2'b00,
    BR_BLTZ = 2'b01,
    BR_BEQ  = 2'b10,
    BR_BNE  = 2'b11
  } branch_type_e;

  // One-hot-ish instruction class; nop is a subset of rtype.
  typedef struct packed {
    logic rtype;
    logic jr;
    logic nop;
    logic j;
    logic jal;
    logic branch;
    logic load;
    logic store;
    logic imm_alu;
    logic lui;
    logic unknown;
  } op_class_t;

  // ALU operation for the immediate-operand instructions (lw/sw/addi use add).
  function automatic alu_op_e imm_alu_op(input logic [OP_W-1:0] op);
    alu_op_e r;
    case (op)
      OP_SLTIU: r = ALU_SLTIU;
      OP_ORI:   r = ALU_ORI;
      OP_LUI:   r = ALU_LUI;
      default:  r = ALU_ADD;
    endcase
    return r;
  endfunction

  // Branch-condition selector for the four branch opcodes.
  function automatic branch_type_e branch_type_of(input logic [OP_W-1:0] op);
    branch_type_e r;
    case (op)
      OP_BEQ:  r = BR_BEQ;
      OP_BNE:  r = BR_BNE;
      OP_BLTZ: r = BR_BLTZ;
      default: r = BR_BLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: shared instruction/data memory port handshake.
//   mem_req_o      : access request (controller -> memory)
//   mem_we_o       : write access (sw)
//   mem_addr_sel_o : address source, 0 = PC, 1 = ALU result
//   mem_ready_i    : memory completes the access this cycle
// master = controller side, slave = memory side.
interface multicycle_ctrl_if;
  logic mem_req_o;
  logic mem_we_o;
  logic mem_addr_sel_o;
  logic mem_ready_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_sel_o,
    input  mem_ready_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_sel_o,
    output mem_ready_i
  );
endinterface

// File: rtl/mc_op_class.sv
// mc_op_class: combinational opcode/funct -> instruction-class decode.
//   instr_op_i : IR[31:26]
//   funct_i    : IR[5:0]
//   cls_o      : instruction class record (op_class_t)
module mc_op_class
  import mc_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output op_class_t          cls_o
);

  always_comb begin
    cls_o = '0;
    case (instr_op_i)
      OP_RTYPE: begin
        if (funct_i == FN_JR) begin
          cls_o.jr = 1'b1;
        end else begin
          cls_o.rtype = 1'b1;
          cls_o.nop   = (funct_i == FN_NOP);
        end
      end
      OP_J:                          cls_o.j       = 1'b1;
      OP_JAL:                        cls_o.jal     = 1'b1;
      OP_BEQ, OP_BNE, OP_BLE, OP_BLTZ: cls_o.branch = 1'b1;
      OP_LW:                         cls_o.load    = 1'b1;
      OP_SW:                         cls_o.store   = 1'b1;
      OP_ADDI, OP_SLTIU, OP_ORI:     cls_o.imm_alu = 1'b1;
      OP_LUI:                        cls_o.lui     = 1'b1;
      default:                       cls_o.unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control sequencer for the MIPS-subset CPU.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath enables and mux selects. Outputs are decoded combinationally from
// the state and the current IR fields; handshake strobes follow mem_ready_i.
// Ports:
//   clk_i, rst_i (async, active-low)
//   instr_op_i, funct_i, branch_taken_i : IR fields and branch condition
//   mem (multicycle_ctrl_if.master)     : shared memory port handshake
//   ir_write_o, mdr_write_o, pc_write_o, pc_src_o, reg_write_o, reg_dst_o,
//   wb_src_o, alu_src_o, alu_op_o, branch_type_o : datapath controls
//   cycle_cnt_o, retire_cnt_o           : performance counters
// Optional feature: define MULTICYCLE_CTRL_PERF_EN to add the CNT_W-wide
// cycle and retired-instruction counters.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
`ifdef MULTICYCLE_CTRL_PERF_EN
#(
  parameter int unsigned CNT_W = 32
)
`endif
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [OP_W-1:0]     instr_op_i,
  input  logic [FUNCT_W-1:0]  funct_i,
  input  logic                branch_taken_i,
  multicycle_ctrl_if.master   mem,
  output logic                ir_write_o,
  output logic                mdr_write_o,
  output logic                pc_write_o,
  output logic [1:0]          pc_src_o,
  output logic                reg_write_o,
  output logic [1:0]          reg_dst_o,
  output logic [1:0]          wb_src_o,
  output logic                alu_src_o,
  output logic [2:0]          alu_op_o,
  output logic [1:0]          branch_type_o
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]    cycle_cnt_o,
  output logic [CNT_W-1:0]    retire_cnt_o
`endif
);

  state_e    r_state;
  state_e    w_next_state;
  op_class_t w_cls;
  logic      w_mem_req;
  logic      w_mem_we;
  logic      w_mem_addr_sel;

  mc_op_class u_op_class (
    .instr_op_i (instr_op_i),
    .funct_i    (funct_i),
    .cls_o      (w_cls)
  );

  // State register; reset parks in IDLE where every output decodes to 0.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_next_state   = r_state;
    w_mem_req      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr_sel = 1'b0;
    ir_write_o     = 1'b0;
    mdr_write_o    = 1'b0;
    pc_write_o     = 1'b0;
    pc_src_o       = PC_SRC_PC4;
    reg_write_o    = 1'b0;
    reg_dst_o      = REG_DST_RT;
    wb_src_o       = WB_SRC_ALU;
    alu_src_o      = 1'b0;
    alu_op_o       = ALU_ADD;
    branch_type_o  = BR_BLE;

    case (r_state)
      S_IDLE: begin
        w_next_state = S_FETCH;
      end

      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem.mem_ready_i) begin
          ir_write_o   = 1'b1;
          pc_write_o   = 1'b1;
          pc_src_o     = PC_SRC_PC4;
          w_next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        if (w_cls.j) begin
          pc_write_o   = 1'b1;
          pc_src_o     = PC_SRC_JUMP;
          w_next_state = S_FETCH;
        end else if (w_cls.jr) begin
          pc_write_o   = 1'b1;
          pc_src_o     = PC_SRC_RS;
          w_next_state = S_FETCH;
        end else if (w_cls.jal) begin
          w_next_state = S_WB;
        end else begin
          w_next_state = S_EXEC;
        end
      end

      S_EXEC: begin
        w_next_state = S_FETCH;
        if (w_cls.branch) begin
          alu_op_o      = ALU_BRCMP;
          branch_type_o = branch_type_of(instr_op_i);
          pc_write_o    = branch_taken_i;
          pc_src_o      = PC_SRC_BRANCH;
        end else if (w_cls.unknown) begin
          // Unknown opcode retires here as a nop with no enables.
          w_next_state = S_FETCH;
        end else if (w_cls.load || w_cls.store) begin
          alu_op_o     = ALU_ADD;
          alu_src_o    = 1'b1;
          w_next_state = S_MEM;
        end else if (w_cls.imm_alu || w_cls.lui) begin
          alu_op_o     = imm_alu_op(instr_op_i);
          alu_src_o    = 1'b1;
          w_next_state = S_WB;
        end else if (w_cls.rtype) begin
          alu_op_o     = ALU_RTYPE;
          w_next_state = S_WB;
        end
      end

      S_MEM: begin
        w_mem_req      = 1'b1;
        w_mem_addr_sel = 1'b1;
        w_mem_we       = w_cls.store;
        if (mem.mem_ready_i) begin
          if (w_cls.load) begin
            mdr_write_o  = 1'b1;
            w_next_state = S_WB;
          end else begin
            w_next_state = S_FETCH;
          end
        end
      end

      S_WB: begin
        // R-type nop keeps its selects but never writes the register file.
        reg_write_o  = !w_cls.nop;
        w_next_state = S_FETCH;
        if (w_cls.jal) begin
          reg_dst_o = REG_DST_RA;
          wb_src_o  = WB_SRC_PC4;
        end else if (w_cls.load) begin
          reg_dst_o = REG_DST_RT;
          wb_src_o  = WB_SRC_MDR;
        end else if (w_cls.lui) begin
          reg_dst_o = REG_DST_RT;
          wb_src_o  = WB_SRC_LUI;
        end else if (w_cls.imm_alu) begin
          reg_dst_o = REG_DST_RT;
          wb_src_o  = WB_SRC_ALU;
        end else begin
          reg_dst_o = REG_DST_RD;
          wb_src_o  = WB_SRC_ALU;
        end
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign mem.mem_req_o      = w_mem_req;
  assign mem.mem_we_o       = w_mem_we;
  assign mem.mem_addr_sel_o = w_mem_addr_sel;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic             w_retire;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_retire_cnt;

  // An instruction retires whenever a post-fetch state hands back to FETCH.
  assign w_retire = (r_state != S_IDLE) && (r_state != S_FETCH) &&
                    (w_next_state == S_FETCH);

  // Free-running cycle and retire counters; both wrap naturally.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (w_retire) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt_o  = r_cycle_cnt;
  assign retire_cnt_o = r_retire_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: self-checking bench for multicycle_ctrl.
// A directed table of instructions (with spec latencies), randomized
// instruction streams with random memory wait states, an async reset in the
// middle of a memory access, and (with MULTICYCLE_CTRL_PERF_EN) counters.
module tb_multicycle_ctrl;

  localparam logic [5:0] C_RTYPE = 6'h00, C_BLTZ = 6'h01, C_J = 6'h02, C_JAL = 6'h03;
  localparam logic [5:0] C_BEQ = 6'h04, C_BNE = 6'h05, C_BLE = 6'h06, C_ADDI = 6'h08;
  localparam logic [5:0] C_SLTIU = 6'h0B, C_ORI = 6'h0D, C_LUI = 6'h0F;
  localparam logic [5:0] C_LW = 6'h23, C_SW = 6'h2B, C_BAD = 6'h3F;

  typedef enum int {PH_IDLE, PH_FETCH, PH_DECODE, PH_EXEC, PH_MEM, PH_WB} phase_e;
  typedef enum int {K_R, K_NOP, K_JR, K_J, K_JAL, K_BR, K_LW, K_SW,
                    K_ADDI, K_SLTIU, K_ORI, K_LUI, K_UNK} kind_e;

  typedef struct packed {
    logic       req, we, asel, irw, mdrw, pcw;
    logic [1:0] pcsrc;
    logic       regw;
    logic [1:0] regdst, wbsrc;
    logic       alusrc;
    logic [2:0] aluop;
    logic [1:0] brt;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       tk;
    int         fw;
    int         mw;
    int         lat;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] instr_op_i = '0;
  logic [5:0] funct_i = '0;
  logic       branch_taken_i = 1'b0;
  logic       ir_write, mdr_write, pc_write, reg_write, alu_src;
  logic [1:0] pc_src, reg_dst, wb_src, br_type;
  logic [2:0] alu_op;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt, retire_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic prev_fetch = 1'b0;
  int fetch_starts[$];

  multicycle_ctrl_if mem_if ();

  multicycle_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .instr_op_i     (instr_op_i),
    .funct_i        (funct_i),
    .branch_taken_i (branch_taken_i),
    .mem            (mem_if),
    .ir_write_o     (ir_write),
    .mdr_write_o    (mdr_write),
    .pc_write_o     (pc_write),
    .pc_src_o       (pc_src),
    .reg_write_o    (reg_write),
    .reg_dst_o      (reg_dst),
    .wb_src_o       (wb_src),
    .alu_src_o      (alu_src),
    .alu_op_o       (alu_op),
    .branch_type_o  (br_type)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cycle_cnt_o    (cycle_cnt),
    .retire_cnt_o   (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle at which each fetch (req with PC address) begins.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_fetch <= 1'b0;
    end else begin
      if (mem_if.mem_req_o && !mem_if.mem_addr_sel_o && !prev_fetch)
        fetch_starts.push_back(cyc);
      prev_fetch <= mem_if.mem_req_o && !mem_if.mem_addr_sel_o;
    end
  end

  function automatic kind_e kind_of(input logic [5:0] op, input logic [5:0] fn);
    kind_e k;
    case (op)
      C_RTYPE: k = (fn == 6'h08) ? K_JR : (fn == 6'h00) ? K_NOP : K_R;
      C_BLTZ, C_BEQ, C_BNE, C_BLE: k = K_BR;
      C_J:     k = K_J;
      C_JAL:   k = K_JAL;
      C_ADDI:  k = K_ADDI;
      C_SLTIU: k = K_SLTIU;
      C_ORI:   k = K_ORI;
      C_LUI:   k = K_LUI;
      C_LW:    k = K_LW;
      C_SW:    k = K_SW;
      default: k = K_UNK;
    endcase
    return k;
  endfunction

  // Expected control outputs for one cycle of an instruction in a given phase.
  function automatic outs_t exp_out(input phase_e ph, input kind_e k, input logic [5:0] op,
                                    input logic tk, input logic rdy);
    outs_t o;
    o = '0;
    case (ph)
      PH_FETCH: begin o.req = 1'b1; o.irw = rdy; o.pcw = rdy; end
      PH_DECODE: begin
        if (k == K_J)  begin o.pcw = 1'b1; o.pcsrc = 2'b11; end
        if (k == K_JR) begin o.pcw = 1'b1; o.pcsrc = 2'b10; end
      end
      PH_EXEC: begin
        case (k)
          K_BR: begin
            o.aluop = 3'b001; o.pcw = tk; o.pcsrc = 2'b01;
            o.brt = (op == C_BEQ) ? 2'b10 : (op == C_BNE) ? 2'b11 :
                    (op == C_BLE) ? 2'b00 : 2'b01;
          end
          K_LW, K_SW, K_ADDI: begin o.alusrc = 1'b1; o.aluop = 3'b000; end
          K_SLTIU: begin o.alusrc = 1'b1; o.aluop = 3'b011; end
          K_ORI:   begin o.alusrc = 1'b1; o.aluop = 3'b100; end
          K_LUI:   begin o.alusrc = 1'b1; o.aluop = 3'b101; end
          K_R, K_NOP: o.aluop = 3'b010;
          default: ;
        endcase
      end
      PH_MEM: begin
        o.req = 1'b1; o.asel = 1'b1; o.we = (k == K_SW); o.mdrw = (k == K_LW) && rdy;
      end
      PH_WB: begin
        o.regw = (k != K_NOP);
        case (k)
          K_JAL:   begin o.regdst = 2'b10; o.wbsrc = 2'b11; end
          K_LW:    begin o.regdst = 2'b00; o.wbsrc = 2'b01; end
          K_LUI:   begin o.regdst = 2'b00; o.wbsrc = 2'b10; end
          K_ADDI, K_SLTIU, K_ORI: begin o.regdst = 2'b00; o.wbsrc = 2'b00; end
          default: begin o.regdst = 2'b01; o.wbsrc = 2'b00; end
        endcase
      end
      default: ;
    endcase
    return o;
  endfunction

  function automatic outs_t sample_outs();
    outs_t o;
    o.req = mem_if.mem_req_o;   o.we = mem_if.mem_we_o;  o.asel = mem_if.mem_addr_sel_o;
    o.irw = ir_write;           o.mdrw = mdr_write;      o.pcw = pc_write;
    o.pcsrc = pc_src;           o.regw = reg_write;      o.regdst = reg_dst;
    o.wbsrc = wb_src;           o.alusrc = alu_src;      o.aluop = alu_op;
    o.brt = br_type;
    return o;
  endfunction

  task automatic check_outs(input string nm, input outs_t got, input outs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %05h expected %05h (req we asel irw mdrw pcw pcsrc regw regdst wbsrc alusrc aluop brt)",
               nm, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // One clock cycle: drive inputs (just after posedge), check at negedge.
  task automatic step(input phase_e ph, input kind_e k, input logic [5:0] op,
                      input logic rdy, input logic tk, input string tag);
    mem_if.mem_ready_i = rdy;
    branch_taken_i     = tk;
    @(negedge clk);
    check_outs($sformatf("%s/%s", tag, ph.name()), sample_outs(), exp_out(ph, k, op, tk, rdy));
    @(posedge clk);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Run one whole instruction with fw fetch waits and mw memory waits.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic tk,
                           input int fw, input int mw, input string tag);
    kind_e  k;
    phase_e path[$];
    k = kind_of(op, fn);
    for (int i = 0; i < fw; i++) step(PH_FETCH, k, op, 1'b0, rbit(), tag);
    step(PH_FETCH, k, op, 1'b1, rbit(), tag);
    instr_op_i = op;
    funct_i    = fn;
    path.push_back(PH_DECODE);
    case (k)
      K_J, K_JR:   ;
      K_JAL:       path.push_back(PH_WB);
      K_BR, K_UNK: path.push_back(PH_EXEC);
      K_LW:        begin path.push_back(PH_EXEC); path.push_back(PH_MEM); path.push_back(PH_WB); end
      K_SW:        begin path.push_back(PH_EXEC); path.push_back(PH_MEM); end
      default:     begin path.push_back(PH_EXEC); path.push_back(PH_WB); end
    endcase
    foreach (path[i]) begin
      if (path[i] == PH_MEM) begin
        for (int w = 0; w < mw; w++) step(PH_MEM, k, op, 1'b0, rbit(), tag);
        step(PH_MEM, k, op, 1'b1, rbit(), tag);
      end else if (path[i] == PH_EXEC && k == K_BR) begin
        step(PH_EXEC, k, op, rbit(), tk, tag);
      end else begin
        step(path[i], k, op, rbit(), rbit(), tag);
      end
    end
  endtask

  vec_t       tbl[18];
  logic [5:0] rops[14];
  int         base;

  initial begin
    tbl[0]  = '{C_LW,    6'h00, 1'b0, 0, 0, 5};
    tbl[1]  = '{C_SW,    6'h00, 1'b0, 0, 3, 7};
    tbl[2]  = '{C_BEQ,   6'h00, 1'b1, 0, 0, 3};
    tbl[3]  = '{C_BEQ,   6'h00, 1'b0, 0, 0, 3};
    tbl[4]  = '{C_JAL,   6'h00, 1'b0, 0, 0, 3};
    tbl[5]  = '{C_RTYPE, 6'h08, 1'b0, 0, 0, 2};
    tbl[6]  = '{C_J,     6'h00, 1'b0, 0, 0, 2};
    tbl[7]  = '{C_RTYPE, 6'h20, 1'b0, 2, 0, 6};
    tbl[8]  = '{C_RTYPE, 6'h00, 1'b0, 0, 0, 4};
    tbl[9]  = '{C_ADDI,  6'h00, 1'b0, 0, 0, 4};
    tbl[10] = '{C_SLTIU, 6'h00, 1'b0, 0, 0, 4};
    tbl[11] = '{C_ORI,   6'h00, 1'b0, 0, 0, 4};
    tbl[12] = '{C_LUI,   6'h00, 1'b0, 1, 0, 5};
    tbl[13] = '{C_BNE,   6'h00, 1'b1, 0, 0, 3};
    tbl[14] = '{C_BLE,   6'h00, 1'b0, 0, 0, 3};
    tbl[15] = '{C_BLTZ,  6'h00, 1'b1, 0, 0, 3};
    tbl[16] = '{C_BAD,   6'h00, 1'b1, 0, 0, 3};
    tbl[17] = '{C_LW,    6'h00, 1'b0, 1, 2, 8};
    rops = '{C_RTYPE, C_BLTZ, C_J, C_JAL, C_BEQ, C_BNE, C_BLE, C_ADDI,
             C_SLTIU, C_ORI, C_LUI, C_LW, C_SW, C_BAD};

    // Reset: everything low, even with ready asserted.
    mem_if.mem_ready_i = 1'b1;
    #1;
    check_outs("reset", sample_outs(), '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(PH_IDLE, K_UNK, 6'h00, 1'b1, 1'b1, "post_reset");

    // Directed table.
    base = fetch_starts.size();
    for (int k = 0; k < 18; k++)
      run_instr(tbl[k].op, tbl[k].fn, tbl[k].tk, tbl[k].fw, tbl[k].mw, $sformatf("tbl%0d", k));

    // Random instruction stream with random wait states.
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op, fn;
      int         r;
      op = rops[$urandom_range(0, 13)];
      if (op == C_BAD) op = 6'($urandom_range(0, 63));
      r  = $urandom_range(0, 4);
      fn = (r == 0) ? 6'h08 : (r == 1) ? 6'h00 : 6'($urandom_range(0, 63));
      run_instr(op, fn, rbit(), $urandom_range(0, 3) * int'(rbit()),
                $urandom_range(0, 3) * int'(rbit()), $sformatf("rnd%0d", n));
    end

    // Table latencies, measured from the DUT's fetch starts.
    for (int k = 0; k < 18; k++) begin
      if (base + k + 1 < fetch_starts.size())
        check_int($sformatf("latency_tbl%0d", k),
                  fetch_starts[base + k + 1] - fetch_starts[base + k], tbl[k].lat);
      else
        check_int($sformatf("latency_tbl%0d_missing", k), 0, tbl[k].lat);
    end

    // Async reset in the middle of a stalled sw access.
    step(PH_FETCH, K_SW, C_SW, 1'b1, 1'b0, "rstm");
    instr_op_i = C_SW;
    funct_i    = 6'h00;
    step(PH_DECODE, K_SW, C_SW, 1'b0, 1'b0, "rstm");
    step(PH_EXEC,   K_SW, C_SW, 1'b0, 1'b0, "rstm");
    step(PH_MEM,    K_SW, C_SW, 1'b0, 1'b0, "rstm");
    mem_if.mem_ready_i = 1'b0;
    #2;
    check_outs("rstm/pre", sample_outs(), exp_out(PH_MEM, K_SW, C_SW, 1'b0, 1'b0));
    rst_n = 1'b0;
    #1;
    check_outs("rstm/async", sample_outs(), '0);
    mem_if.mem_ready_i = 1'b1;
    @(posedge clk);
    #1;
    check_outs("rstm/held", sample_outs(), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(PH_IDLE, K_UNK, C_SW, 1'b1, 1'b0, "rstm_release");

    // Ten zero-wait R-type instructions straight out of reset.
    for (int n = 0; n < 10; n++)
      run_instr(C_RTYPE, 6'h21, 1'b0, 0, 0, $sformatf("perf%0d", n));
`ifdef MULTICYCLE_CTRL_PERF_EN
    check_int("cycle_cnt", int'(cycle_cnt), 41);
    check_int("retire_cnt", int'(retire_cnt), 10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
